// File: rtl/ps2_key_matrix.sv
// PS/2 scancode stream to UT-88 keyboard matrix: held-key map, shift/caps, port 05/06/A0 reads.
// Ports: clk, rst (async active-low), rx_data/rx_valid in, clear, row_sel in; col_data, mod_data,
//   any_key, key_shift, key_caps, hex_key, hex_valid out. Optional: KBD_HEXKEY_EN builds hex-key map.
module ps2_key_matrix #(
    parameter int unsigned ERR_TIMEOUT = 100_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       clear,
    input  logic [7:0] row_sel,
    output logic [7:0] col_data,
    output logic [7:0] mod_data,
    output logic       any_key,
    output logic       key_shift,
    output logic       key_caps,
    output logic [7:0] hex_key,
    output logic       hex_valid
);

    localparam int CW = (ERR_TIMEOUT > 1) ? $clog2(ERR_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ERR_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic          do_make, do_brk, do_flush;
    logic          act_make, act_brk, act_flush;
    logic [7:0]    act_code;

    logic [255:0]  key_map;
    logic [255:0]  map_nomod;
    logic          shift_l, shift_r, caps;

    logic          is_fake;
    logic          is_flush;

    // E0 12 / E0 7C are the fake-shift wrappers sent around extended keys.
    assign is_fake  = (rx_data == 8'h12) || (rx_data == 8'h7C);
    assign is_flush = (rx_data == 8'hAA) || (rx_data == 8'h00) ||
                      (rx_data == 8'hFF);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        do_make  = 1'b0;
        do_brk   = 1'b0;
        do_flush = 1'b0;
        if (state != S_IDLE) begin
            cnt_n = cnt + 1'b1;
        end
        if (rx_valid) begin
            cnt_n = '0;
            unique case (state)
                S_IDLE: begin
                    if (rx_data == 8'hE0) begin
                        state_n = S_EXT;
                    end else if (rx_data == 8'hF0) begin
                        state_n = S_BRK;
                    end else if (is_flush) begin
                        do_flush = 1'b1;
                    end else begin
                        do_make = 1'b1;
                    end
                end
                S_EXT: begin
                    if (rx_data == 8'hF0) begin
                        state_n = S_EXT_BRK;
                    end else begin
                        state_n = S_IDLE;
                        do_make = !is_fake;
                    end
                end
                S_BRK: begin
                    state_n = S_IDLE;
                    do_brk  = 1'b1;
                end
                S_EXT_BRK: begin
                    state_n = S_IDLE;
                    do_brk  = !is_fake;
                end
                default: state_n = S_IDLE;
            endcase
        end else if (state != S_IDLE && cnt == CNT_LAST) begin
            // Prefix never completed: abandon it silently.
            state_n = S_IDLE;
            cnt_n   = '0;
        end
        if (clear) begin
            state_n  = S_IDLE;
            cnt_n    = '0;
            do_make  = 1'b0;
            do_brk   = 1'b0;
            do_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            act_make  <= 1'b0;
            act_brk   <= 1'b0;
            act_flush <= 1'b0;
            act_code  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            act_make  <= do_make;
            act_brk   <= do_brk;
            act_flush <= do_flush;
            act_code  <= rx_data;
        end
    end

    // Bit 58 doubles as the caps key's held flag so typematic repeats
    // do not re-toggle caps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_map <= '0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
            caps    <= 1'b0;
        end else if (clear || act_flush) begin
            key_map <= '0;
            shift_l <= 1'b0;
            shift_r <= 1'b0;
        end else if (act_make) begin
            unique case (act_code)
                8'h12: shift_l <= 1'b1;
                8'h59: shift_r <= 1'b1;
                8'h58: begin
                    if (!key_map[8'h58]) begin
                        caps <= ~caps;
                    end
                    key_map[8'h58] <= 1'b1;
                end
                default: key_map[act_code] <= 1'b1;
            endcase
        end else if (act_brk) begin
            unique case (act_code)
                8'h12:   shift_l <= 1'b0;
                8'h59:   shift_r <= 1'b0;
                default: key_map[act_code] <= 1'b0;
            endcase
        end
    end

    always_comb begin
        map_nomod        = key_map;
        map_nomod[8'h58] = 1'b0;
    end

    assign any_key   = |map_nomod;
    assign key_shift = shift_l | shift_r;
    assign key_caps  = caps;

    // Scancodes of one matrix row, bit 6 code in the top byte.
    function automatic logic [55:0] row_codes(
        input logic [2:0] r,
        input logic       sh,
        input logic       cp
    );
        logic [55:0] c;
        c = '0;
        unique case (r)
            3'd0: c = {8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45};
            3'd1: c = {(sh ? 8'h55 : 8'h4E),
                       8'h41, 8'h4C, 8'h4C, 8'h46, 8'h3E, 8'h3D};
            3'd2: c = {(cp ? 8'h4B : 8'h23), (cp ? 8'h1D : 8'h21),
                       (cp ? 8'h41 : 8'h32), (cp ? 8'h2B : 8'h1C),
                       8'h1E, 8'h4A, 8'h49};
            3'd3: c = {8'h42, 8'h3B, 8'h43, 8'h33, 8'h34, 8'h2B, 8'h24};
            3'd4: c = {8'h2D, 8'h15, 8'h4D, 8'h44, 8'h31, 8'h3A, 8'h4B};
            3'd5: c = {8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B};
            3'd6: c = {8'h29, 8'h71, 8'h70, 8'h5B, 8'h5D, 8'h54, 8'h1A};
            3'd7: c = {8'h6C, 8'h77, 8'h5A, 8'h72, 8'h75, 8'h6B, 8'h74};
            default: c = '0;
        endcase
        return c;
    endfunction

    logic [2:0]  row_idx;
    logic        row_hit;
    logic [55:0] codes;
    logic [6:0]  pressed;
    logic [7:0]  col_n;
    logic [7:0]  mod_n;

    always_comb begin
        row_idx = '0;
        row_hit = 1'b0;
        // Walk downward so the lowest selected row wins.
        for (int i = 7; i >= 0; i--) begin
            if (!row_sel[i]) begin
                row_idx = 3'(i);
                row_hit = 1'b1;
            end
        end
        codes = row_codes(row_idx, key_shift, caps);
        for (int b = 0; b < 7; b++) begin
            pressed[b] = key_map[codes[b*8 +: 8]];
        end
        if (row_sel == 8'h00) begin
            col_n = any_key ? 8'h00 : 8'h7F;
        end else if (!row_hit) begin
            col_n = 8'h7F;
        end else begin
            col_n = {1'b0, ~pressed};
        end
        mod_n = ~{1'b1, 4'b0000, key_shift, 1'b0, caps};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_data <= 8'h7F;
            mod_data <= 8'h7F;
        end else begin
            col_data <= col_n;
            mod_data <= mod_n;
        end
    end

`ifdef KBD_HEXKEY_EN
    function automatic logic [7:0] hex_map(input logic [7:0] code);
        logic [7:0] h;
        unique case (code)
            8'h45:   h = 8'h10;
            8'h16:   h = 8'h01;
            8'h1E:   h = 8'h02;
            8'h26:   h = 8'h03;
            8'h25:   h = 8'h04;
            8'h2E:   h = 8'h05;
            8'h36:   h = 8'h06;
            8'h3D:   h = 8'h07;
            8'h3E:   h = 8'h08;
            8'h46:   h = 8'h09;
            8'h1C:   h = 8'h0A;
            8'h32:   h = 8'h0B;
            8'h21:   h = 8'h0C;
            8'h23:   h = 8'h0D;
            8'h24:   h = 8'h0E;
            8'h2B:   h = 8'h0F;
            8'h76:   h = 8'h80;
            default: h = 8'h00;
        endcase
        return h;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hex_key   <= '0;
            hex_valid <= 1'b0;
        end else begin
            hex_valid <= act_make & ~clear;
            if (act_make && !clear) begin
                hex_key <= hex_map(act_code);
            end
        end
    end
`else
    assign hex_key   = 8'h00;
    assign hex_valid = 1'b0;
`endif

endmodule
